// File: rtl/icache_pkg.sv
// Shared geometry, FSM encodings and address layout for the direct-mapped icache.
package icache_pkg;

  localparam int unsigned WORD_SIZE        = 32;
  localparam int unsigned BLOCK_SIZE       = 128;
  localparam int unsigned BYTE_SIZE        = 8;
  localparam int unsigned ICACHE_LINES     = 16;
  localparam int unsigned ICACHE_OFF_BITS  = $clog2(BLOCK_SIZE / BYTE_SIZE);
  localparam int unsigned ICACHE_IDX_BITS  = $clog2(ICACHE_LINES);
  localparam int unsigned ICACHE_TAG_BITS  = WORD_SIZE - ICACHE_OFF_BITS - ICACHE_IDX_BITS;
  localparam int unsigned ICACHE_WSEL_BITS = ICACHE_OFF_BITS - 2;
  localparam int unsigned ICACHE_WORDS     = BLOCK_SIZE / WORD_SIZE;

  localparam logic [1:0] ICACHE_IDLE  = 2'd0;
  localparam logic [1:0] ICACHE_FETCH = 2'd1;
  localparam logic [1:0] ICACHE_FILL  = 2'd2;

  typedef struct packed {
    logic [ICACHE_TAG_BITS-1:0]  tag;
    logic [ICACHE_IDX_BITS-1:0]  idx;
    logic [ICACHE_WSEL_BITS-1:0] wsel;
    logic [1:0]                  bsel;
  } icache_addr_t;

  // Line-aligned base address of the block containing addr.
  function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
    return {addr[WORD_SIZE-1:ICACHE_OFF_BITS], {ICACHE_OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_word_sel.sv
// Picks one instruction word out of a line; word 0 sits in the most significant bits.
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [BLOCK_SIZE-1:0]       i_line,
  input  logic [ICACHE_WSEL_BITS-1:0] i_wsel,
  output logic [WORD_SIZE-1:0]        o_word_c
);

  always_comb begin
    o_word_c = '0;
    for (int i = 0; i < int'(ICACHE_WORDS); i++) begin
      if (i_wsel == ICACHE_WSEL_BITS'(i)) begin
        o_word_c = i_line[BLOCK_SIZE-1-WORD_SIZE*i -: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, FETCH/FILL miss path to instmem.
// Optional ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module icache
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [WORD_SIZE-1:0]  cpu_addr,
  input  logic                  cpu_flush,
  output logic                  cpu_ready,
  output logic [WORD_SIZE-1:0]  cpu_inst,
  output logic [WORD_SIZE-1:0]  mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_block
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]  hit_count,
  output logic [WORD_SIZE-1:0]  miss_count
`endif
);

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_nxt;
  logic                       r_ready;
  logic [WORD_SIZE-1:0]       r_inst;
  logic [WORD_SIZE-1:0]       r_mem_addr;
  logic [ICACHE_LINES-1:0]    r_valid;
  logic [BLOCK_SIZE-1:0]      r_data [ICACHE_LINES];
  logic [ICACHE_TAG_BITS-1:0] r_tag  [ICACHE_LINES];
  icache_addr_t               r_addr;

  icache_addr_t               w_req;
  logic                       w_hit;
  logic [BLOCK_SIZE-1:0]      w_hit_line;
  logic [WORD_SIZE-1:0]       w_hit_word;
  logic [WORD_SIZE-1:0]       w_fill_word;
  logic                       w_ready_nxt;
  logic [WORD_SIZE-1:0]       w_inst_nxt;
  logic [WORD_SIZE-1:0]       w_mem_addr_nxt;
  logic                       w_latch;
  logic                       w_fill;
  logic                       w_hit_evt;
  logic                       w_miss_evt;
  logic                       w_unused_bsel;

  assign w_req         = icache_addr_t'(cpu_addr);
  assign w_hit_line    = r_data[w_req.idx];
  assign w_unused_bsel = ^{w_req.bsel, r_addr.bsel};

  // A flush in the same cycle turns any would-be hit into a miss.
  assign w_hit = r_valid[w_req.idx] && (r_tag[w_req.idx] == w_req.tag) && !cpu_flush;

  icache_word_sel u_hit_sel (
    .i_line   (w_hit_line),
    .i_wsel   (w_req.wsel),
    .o_word_c (w_hit_word)
  );

  icache_word_sel u_fill_sel (
    .i_line   (mem_block),
    .i_wsel   (r_addr.wsel),
    .o_word_c (w_fill_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ICACHE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values for every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_ready_nxt    = 1'b0;
    w_inst_nxt     = r_inst;
    w_mem_addr_nxt = r_mem_addr;
    w_latch        = 1'b0;
    w_fill         = 1'b0;
    w_hit_evt      = 1'b0;
    w_miss_evt     = 1'b0;
    case (r_state)
      ICACHE_IDLE: begin
        if (cpu_req) begin
          if (w_hit) begin
            w_ready_nxt = 1'b1;
            w_inst_nxt  = w_hit_word;
            w_hit_evt   = 1'b1;
          end else begin
            w_state_nxt    = ICACHE_FETCH;
            w_latch        = 1'b1;
            w_mem_addr_nxt = line_base(cpu_addr);
            w_miss_evt     = 1'b1;
          end
        end
      end
      ICACHE_FETCH: begin
        w_state_nxt = cpu_flush ? ICACHE_IDLE : ICACHE_FILL;
      end
      ICACHE_FILL: begin
        w_state_nxt = ICACHE_IDLE;
        if (!cpu_flush) begin
          w_fill      = 1'b1;
          w_ready_nxt = 1'b1;
          w_inst_nxt  = w_fill_word;
        end
      end
      default: begin
        w_state_nxt = ICACHE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_inst     <= '0;
      r_mem_addr <= '0;
      r_valid    <= '0;
    end else begin
      r_ready    <= w_ready_nxt;
      r_inst     <= w_inst_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      if (cpu_flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[r_addr.idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage and the latched miss address carry no reset.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_addr <= w_req;
    end
    if (w_fill && !rst) begin
      r_data[r_addr.idx] <= mem_block;
      r_tag[r_addr.idx]  <= r_addr.tag;
    end
  end

  assign cpu_ready = r_ready;
  assign cpu_inst  = r_inst;
  assign mem_addr  = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [WORD_SIZE-1:0] r_hit_count;
  logic [WORD_SIZE-1:0] r_miss_count;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_evt && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + WORD_SIZE'(1);
      end
      if (w_miss_evt && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + WORD_SIZE'(1);
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_hit_evt ^ w_miss_evt;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: byte-image instmem, line-state model, per-cycle compare.
module tb_icache;

  localparam int NCYC = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_flush;
  logic         cpu_ready;
  logic [31:0]  cpu_inst;
  logic [31:0]  mem_addr;
  logic [127:0] mem_block;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_flush (cpu_flush),
    .cpu_ready (cpu_ready),
    .cpu_inst  (cpu_inst),
    .mem_addr  (mem_addr),
    .mem_block (mem_block)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  bit          exp_ready [NCYC];
  logic [31:0] exp_inst  [NCYC];
  bit          exp_mv    [NCYC];
  logic [31:0] exp_ma    [NCYC];

  // Model of cache contents: which memory line each index holds.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  function automatic logic [7:0] img(input logic [31:0] a);
    logic [11:0] i;
    i = a[11:0];
    return i[7:0] ^ {4'b0, i[11:8]};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] a0;
    a0 = {a[31:2], 2'b00};
    return {img(a0), img(a0 + 32'd1), img(a0 + 32'd2), img(a0 + 32'd3)};
  endfunction

  function automatic logic [127:0] block_of(input logic [31:0] base);
    logic [127:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) b[127-8*j -: 8] = img(base + 32'(j));
    return b;
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_block <= block_of(mem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errs++;
      $display("FAIL %s (cycle %0d): got %08h want %08h", nm, cyc, act, want);
    end
  endtask

  // Every cycle: ready pulse pattern, returned word, and FETCH address.
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, exp_ready[cyc]});
      if (exp_ready[cyc]) chk("cpu_inst", cpu_inst, exp_inst[cyc]);
      if (exp_mv[cyc])    chk("mem_addr", mem_addr, exp_ma[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // Issue one request in the current cycle; returns when the next request may start.
  task automatic issue(input logic [31:0] a, input logic fl);
    int c;
    bit hit;
    c   = cyc;
    hit = m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]) && !fl;
    if (fl) model_clear();
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_flush = fl;
    if (hit) begin
      exp_ready[c+1] = 1'b1;
      exp_inst[c+1]  = word_of(a);
      step();
      cpu_req   = 1'b0;
      cpu_flush = 1'b0;
    end else begin
      exp_mv[c+1]     = 1'b1;
      exp_ma[c+1]     = {a[31:4], 4'h0};
      exp_ready[c+3]  = 1'b1;
      exp_inst[c+3]   = word_of(a);
      m_valid[a[7:4]] = 1'b1;
      m_tag[a[7:4]]   = a[31:8];
      step();
      cpu_flush = 1'b0;
      step();
      step();
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    int c;
    for (int i = 0; i < NCYC; i++) begin
      exp_ready[i] = 1'b0;
      exp_inst[i]  = '0;
      exp_mv[i]    = 1'b0;
      exp_ma[i]    = '0;
    end
    model_clear();
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_flush = 1'b0;
    repeat (3) step();
    chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_inst", cpu_inst, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("model_w0", word_of(32'h0), 32'h00010203);
    chk("model_w100", word_of(32'h100), 32'h01000302);
    rst = 1'b0;
    chk_en = 1'b1;

    // Cold miss on line 0, then three back-to-back hits.
    issue(32'h00, 1'b0);
    chk("lit_first_ready", {31'b0, cpu_ready}, 32'd1);
    chk("lit_first_inst", cpu_inst, 32'h00010203);
    issue(32'h04, 1'b0);
    issue(32'h08, 1'b0);
    issue(32'h0C, 1'b0);
    chk("lit_hit_c", cpu_inst, 32'h0C0D0E0F);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'd3);
    chk("miss_count", miss_count, 32'd1);
`endif
    step();

    // Conflict misses on index 0, unaligned hit.
    issue(32'h100, 1'b0);
    chk("lit_conflict", cpu_inst, 32'h01000302);
    issue(32'h00, 1'b0);
    issue(32'h06, 1'b0);
    chk("lit_unaligned", cpu_inst, 32'h04050607);

    // Highest index and last word in the line.
    issue(32'hF0, 1'b0);
    issue(32'hFC, 1'b0);
    step();

    // Flush pulse in IDLE, then a miss on previously valid line.
    cpu_flush = 1'b1;
    model_clear();
    step();
    cpu_flush = 1'b0;
    issue(32'h04, 1'b0);
    issue(32'h08, 1'b0);
    // Flush concurrent with a request that would hit.
    issue(32'h0C, 1'b1);
    issue(32'h00, 1'b0);
    step();

    // Flush during FETCH aborts; immediate re-request must be accepted.
    c = cyc;
    cpu_req = 1'b1; cpu_addr = 32'h130;
    exp_mv[c+1] = 1'b1;
    exp_ma[c+1] = 32'h130;
    step();
    cpu_flush = 1'b1; cpu_req = 1'b0;
    model_clear();
    step();
    cpu_flush = 1'b0;
    issue(32'h34, 1'b0);
    issue(32'h38, 1'b0);
    step();

    // Reset during FILL: no ready, everything invalid afterwards.
    c = cyc;
    cpu_req = 1'b1; cpu_addr = 32'h00;
    exp_mv[c+1] = 1'b1;
    exp_ma[c+1] = 32'h00;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; cpu_req = 1'b0;
    model_clear();
    chk("rst_fill_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_fill_inst", cpu_inst, 32'd0);
    issue(32'h00, 1'b0);
    issue(32'h38, 1'b0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and `instmem`.
- Serves 32-bit instruction words to the CPU with one-cycle hit latency.
- On a miss, drives a line-aligned address to `instmem`, captures the returned `BLOCK_SIZE`-bit block, fills the line and replies.
- Block byte order matches `instmem`: byte at the lowest address is most significant.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): CPU address and instruction width.
- BLOCK_SIZE, `BLOCK_SIZE (128): line width in bits; equals the `instmem` output width.
- BYTE_SIZE, `BYTE_SIZE (8): bits per byte.
- LINES, 16: number of cache lines; power of two.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  fetch request, sampled only in IDLE
- cpu_addr  in  WORD_SIZE  byte address of the instruction
- cpu_flush  in  1  invalidate all lines
- cpu_ready  out  1  one-cycle pulse; cpu_inst valid
- cpu_inst  out  WORD_SIZE  fetched instruction word
- mem_addr  out  WORD_SIZE  line-aligned address to `instmem` `in`
- mem_block  in  BLOCK_SIZE  `instmem` `out`; valid the cycle after mem_addr is sampled

Behaviour:
- Only one clock and one reset exist. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - all valid bits = 0
  - cpu_ready = 0, cpu_inst = 0, mem_addr = 0
  - tag/data arrays are not reset.
- Address split:
  - OFF = log2(BLOCK_SIZE/BYTE_SIZE)
  - IDX = log2(LINES)
  - index = addr[OFF+IDX-1:OFF]
  - tag = addr[WORD_SIZE-1:OFF+IDX]
  - word sel w = addr[OFF-1:2]
  - addr[1:0] are ignored; unaligned requests return the containing aligned word.
- Word extract: cpu_inst = line[BLOCK_SIZE-1-WORD_SIZE*w -: WORD_SIZE].
- IDLE:
  - cpu_req=1 with a hit: at the edge, register cpu_inst and set cpu_ready=1; stay in IDLE.
  - Hits therefore sustain one word per cycle with latency 1.
  - cpu_req=1 with a miss: latch the request address, go to FETCH, cpu_ready=0.
  - cpu_req=0: cpu_ready=0.
- FETCH (1 cycle): mem_addr = {latched_addr[WORD_SIZE-1:OFF], OFF'b0}; `instmem` samples it at the edge leaving FETCH. Next state is FILL.
- FILL (1 cycle): on mem_block at the edge leaving FILL:
  - write data[index] and tag[index], set valid[index]=1
  - register cpu_inst from mem_block, set cpu_ready=1
  - go to IDLE
- Miss latency: request edge E0, then cpu_ready high in the cycle after E0+3 edges, i.e. the 3rd cycle after acceptance.
- cpu_req/cpu_addr in FETCH/FILL are ignored; the CPU holds cpu_req until cpu_ready.
- mem_addr holds its last value outside FETCH.
- Flush:
  - cpu_flush=1 clears all valid bits at the edge and has priority over any fill.
  - In IDLE, a concurrent request is treated as a miss.
  - In FETCH/FILL, the miss is aborted: no write, no cpu_ready, next state IDLE. The CPU re-requests.
- Reset mid-miss: same as reset; no cpu_ready pulse.
- Every edge where cpu_ready is not set by a hit or a FILL clears cpu_ready.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - adds outputs hit_count and miss_count, each WORD_SIZE wide.
  - hit_count increments on each IDLE hit; miss_count increments on each IDLE→FETCH transition.
  - both are saturating, cleared by rst, and not cleared by cpu_flush.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Add to define.v:
  - ICACHE_LINES
  - ICACHE_OFF_BITS, ICACHE_IDX_BITS
  - state encodings ICACHE_IDLE=2'd0, ICACHE_FETCH=2'd1, ICACHE_FILL=2'd2
- One sub-module: icache_word_sel, purely combinational (line, w) → word, reused for the hit and fill paths.

Test Plan:
- Memory image: byte i = i[7:0] ^ {4'b0, i[11:8]}. LINES=16, BLOCK_SIZE=128.
- Reset, req 0x00 → mem_addr=0x00 in FETCH; cpu_ready in 3rd cycle; cpu_inst=0x00010203; one-cycle pulse.
- After the above, back-to-back reqs 0x04, 0x08, 0x0C → three consecutive ready cycles, latency 1: 0x04050607, 0x08090A0B, 0x0C0D0E0F; no FETCH.
- Req 0x100 (same index as 0x00) → miss, cpu_inst=0x01000302. Then req 0x00 → miss again, 0x00010203.
- Req 0x06 after line 0 filled → hit, 0x04050607.
- Pulse cpu_flush in IDLE, then req 0x04 → miss path taken. Separately, flush during FETCH → no cpu_ready, state IDLE; re-request returns the correct data.
- Assert rst during FILL → cpu_ready stays 0, all valid cleared; next req 0x00 misses.
- With ICACHE_STATS_EN: after scenarios 1–2, hit_count=3 and miss_count=1.
